// File: rtl/fpu_32_pkg.sv
// ---------------------------------------------------------------------------
// fpu_32_pkg
// Shared definitions for the FPU issue queue: opcode encodings, the issue
// FSM state type, a few IEEE-754 single-precision constants and a helper
// that tells whether an opcode produces meaningful overflow/underflow flags.
// ---------------------------------------------------------------------------
package fpu_32_pkg;

    // FPU opcode encodings (3'd6 is also treated as NOP by the FPU).
    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_DIV     = 3'd3;
    localparam logic [2:0] OP_RECIP_A = 3'd4;
    localparam logic [2:0] OP_RECIP_B = 3'd5;
    localparam logic [2:0] OP_NOP     = 3'd7;

    // Issue FSM: IDLE -> DRIVE -> CAPT -> HOLD -> (DRIVE | IDLE).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // IEEE-754 single-precision constants.
    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

    // The FPU only refreshes its flags for the arithmetic ops 000..011;
    // for RECIP and NOP its flag outputs are stale and must be ignored.
    function automatic logic op_has_flags(input logic [2:0] op);
        return (op <= OP_DIV);
    endfunction

endpackage

// File: rtl/fpu_32_sync_fifo.sv
// ---------------------------------------------------------------------------
// fpu_32_sync_fifo
// Single-clock FIFO, W bits wide and DEPTH entries deep (DEPTH a power of 2).
// The head entry is presented combinationally on rdata_o whenever non-empty.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_i, wdata_i write request and data (ignored when full)
//   pop_i           remove head entry (ignored when empty)
//   rdata_o         head entry
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fpu_32_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    // NOTE: every variable written here gets a default first so no latch is
    // inferred on the paths where no case arm assigns it.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values, independent of block ordering.
    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, and a reset-free array maps onto
    // plain RAM/flop arrays without a reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpu_32_issue_queue.sv
// ---------------------------------------------------------------------------
// fpu_32_issue_queue
// Command stage in front of the registered 32-bit FPU. Requests
// {opcode, A, B, tag} are queued in a DEPTH-entry FIFO, issued one at a time
// on registered fpu_* outputs, and the FPU result (one edge of latency) is
// captured with its tag into an output register held under backpressure.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_valid/in_ready                 request handshake (in_ready = !full)
//   in_opcode, in_a, in_b, in_tag     request payload
//   fpu_opcode, fpu_a, fpu_b          registered operands to the FPU
//   fpu_result, fpu_overflow/underflow  FPU response
//   out_valid/out_ready               result handshake
//   out_result, out_overflow/underflow, out_tag  captured result (flags
//                                     masked to 0 for RECIP/NOP)
//   busy                              queue non-empty or an op in flight
// Optional (macro FPU_ISSUE_STICKY_EN):
//   sticky_clr                        clears sticky flags (a set wins)
//   sticky_overflow/underflow         accumulated masked flags
// ---------------------------------------------------------------------------
module fpu_32_issue_queue
    import fpu_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [2:0]       fpu_opcode,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_overflow,
    input  logic             fpu_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef FPU_ISSUE_STICKY_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky_overflow,
    output logic             sticky_underflow
`endif
);

    localparam int PW = 3 + 2 * WIDTH + TAG_W;
    localparam int CW = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PW-1:0]    fifo_wdata, fifo_rdata;
    logic [CW-1:0]    fifo_count;

    logic [2:0]       opcode_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [TAG_W-1:0] tag_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             out_ovf_q, out_unf_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             ovf_masked, unf_masked;

    // in_ready depends only on the FIFO being full, never on a same-cycle pop.
    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && !fifo_full;
    assign fifo_wdata = {in_opcode, in_a, in_b, in_tag};

    fpu_32_sync_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state logic; the pop strobe is issued from IDLE, or from HOLD in
    // the same edge the current result is accepted, to keep 3 cycles per op.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_DRIVE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Operand registers: loaded only on a pop, so they stay stable for the
    // whole DRIVE/CAPT/HOLD window of the op they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
        end else if (fifo_pop) begin
            {opcode_q, a_q, b_q, tag_q} <= fifo_rdata;
        end
    end

    assign ovf_masked = op_has_flags(opcode_q) && fpu_overflow;
    assign unf_masked = op_has_flags(opcode_q) && fpu_underflow;

    // Result register: captured in CAPT, frozen in HOLD until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
            out_tag_q    <= '0;
        end else if (state_q == ST_CAPT) begin
            out_valid_q  <= 1'b1;
            out_result_q <= fpu_result;
            out_ovf_q    <= ovf_masked;
            out_unf_q    <= unf_masked;
            out_tag_q    <= tag_q;
        end else if ((state_q == ST_HOLD) && out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

`ifdef FPU_ISSUE_STICKY_EN
    logic sticky_ovf_q, sticky_unf_q;
    logic capt;

    assign capt = (state_q == ST_CAPT);

    // Clear is applied first and the set term OR'd after it, so a capture
    // in the same cycle as sticky_clr leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            sticky_ovf_q <= (sticky_ovf_q && !sticky_clr) || (capt && ovf_masked);
            sticky_unf_q <= (sticky_unf_q && !sticky_clr) || (capt && unf_masked);
        end
    end

    assign sticky_overflow  = sticky_ovf_q;
    assign sticky_underflow = sticky_unf_q;
`endif

    assign fpu_opcode    = opcode_q;
    assign fpu_a         = a_q;
    assign fpu_b         = b_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_overflow  = out_ovf_q;
    assign out_underflow = out_unf_q;
    assign out_tag       = out_tag_q;
    assign busy          = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: doc/fpu_32_issue_queue.md
Name: fpu_32_issue_queue

Overview:
Upstream command stage for the registered 32-bit FPU. Buffers tagged operation requests (opcode, A, B, tag) in a small FIFO behind a valid/ready handshake. Issues them one at a time to the FPU and tracks the FPU's one-edge register latency. Captures each result, with its flags and tag, into an output register held under valid/ready backpressure.

Parameters:
WIDTH, 32, operand/result width (IEEE-754 single)
DEPTH, 4, command FIFO entries; power of 2, >= 2
TAG_W, 4, request tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  FIFO can accept; equals !full
in_opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 RECIP_A, 101 RECIP_B, others NOP
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_tag  in  TAG_W  request tag, returned with result
fpu_opcode  out  3  to FPU OpCode
fpu_a  out  WIDTH  to FPU A
fpu_b  out  WIDTH  to FPU B
fpu_result  in  WIDTH  from FPU Result
fpu_overflow  in  1  from FPU overflow
fpu_underflow  in  1  from FPU underflow
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_result  out  WIDTH  captured result
out_overflow  out  1  masked overflow
out_underflow  out  1  masked underflow
out_tag  out  TAG_W  tag of this result
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset (async, rst=1): FIFO empty (pointers and count 0); state IDLE.
- Reset values: fpu_opcode=3'b111; fpu_a=0; fpu_b=0; out_valid=0; out_result=0; out_overflow=0; out_underflow=0; out_tag=0; in_ready=1; busy=0.
- Reset during any state discards the in-flight op and all queued ops. No partial result is emitted.
- Push: occurs when in_valid && in_ready. in_ready is purely !full; it is not raised by a same-cycle pop.
- fpu_a, fpu_b and fpu_opcode are registers and stay stable between issues. The held tag is an internal register.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the operand registers and go to DRIVE.
  - DRIVE: operands stable; the FPU samples them at this cycle's closing edge. Go to CAPT.
  - CAPT: fpu_result is valid. At the edge, load out_result and out_tag, set out_valid=1, go to HOLD.
  - HOLD: outputs frozen while !out_ready. On out_ready, clear out_valid. Then, if FIFO non-empty, pop in the same edge and go to DRIVE; otherwise go to IDLE.
- Flag masking: out_overflow and out_underflow take fpu_* flags only for opcodes 000–011. They are forced to 0 for RECIP and NOP, because the FPU does not refresh its flags on those ops.
- Latency: with an empty queue, a push at edge 0 gives out_valid=1 after edge 3. Sustained throughput is one op per 3 cycles with out_ready=1.
- Capacity: DEPTH queued entries plus 1 in flight.
- Ordering: strictly FIFO; tags are returned in push order.
- Simultaneous push and pop when not full: count unchanged, pointers wrap mod DEPTH.
- Push when full: impossible by handshake; in_valid is ignored when in_ready=0.

Optional Feature:
FPU_ISSUE_STICKY_EN
- Defined: adds input sticky_clr (1 bit) and outputs sticky_overflow and sticky_underflow.
  - Each sticky bit is set when a result carrying the corresponding masked flag is captured in CAPT.
  - Each is cleared by sticky_clr or rst. If set and clear happen in the same cycle, set wins.
- Undefined: these ports and registers do not exist.

Decomposition:
- Package fpu_32_pkg holds:
  - opcode localparams OP_ADD=3'd0, OP_SUB=3'd1, OP_MUL=3'd2, OP_DIV=3'd3, OP_RECIP_A=3'd4, OP_RECIP_B=3'd5, OP_NOP=3'd7
  - the FSM state encoding
  - the 1.0, +INF and zero constants
- One sub-module: fpu_32_sync_fifo, a parameterised width/depth FIFO with full/empty/count. Payload is {opcode, A, B, tag}, 3+2*WIDTH+TAG_W bits.

Test Plan:
- ADD 0x3F800000 + 0x40000000, tag 5, with a modelled FPU → out_result=0x40400000, tag 5, flags 0; out_valid rises exactly 3 edges after accept.
- out_ready=0, in_valid held → exactly DEPTH+1=5 accepts, then in_ready=0. Release out_ready → 5 results in tag order 0..4, each held until accepted.
- MUL 0x7F000000 × 0x7F000000, then RECIP_A 0x40000000 → first has out_overflow=1; second has out_result=0x3F000000, out_overflow=0 (masked).
- Assert rst while in CAPT with 2 queued ops → all outputs return to reset values immediately; no further out_valid without new pushes.
- Push and pop every cycle across 3×DEPTH ops → pointers wrap; no loss or duplication; count never exceeds DEPTH.
- With FPU_ISSUE_STICKY_EN: overflowing MUL sets sticky_overflow=1; it survives a clean ADD; sticky_clr clears it; sticky_clr in the same cycle as an overflow capture leaves it 1.
